// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_search_ctrl
// Purpose  : Successive-approximation search controller. It drives a trial
//            value to an external magnitude comparator and narrows in on the
//            target one bit per cycle, MSB first.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   width of guess / result (1..8)
// Ports
//   clk     clock, rising edge
//   rst_n   synchronous active-low reset
//   start   begin a new search (accepted only while idle)
//   cmp_in  comparator result {target>guess, target==guess, target<guess}
//   guess   trial value presented to the comparator
//   busy    search in progress
//   done    one-cycle completion pulse
//   result  converged value, held until the next accepted start
//   err     search aborted on a non-one-hot cmp_in code (valid with done)
// Configuration
//   SAR_EARLY_EXIT_EN  when defined, a trial that hits target==guess ends
//                      the search immediately (same result, shorter latency)
// ============================================================================
module sar_search_ctrl #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       cmp_in,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int               c_IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IW-1:0]  c_IDX_TOP = c_IW'(WIDTH - 1);
    localparam logic [c_IW-1:0]  c_IDX_ONE = c_IW'(1);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_MSB     = c_ONE << (WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TRIAL = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [c_IW-1:0]  r_idx;
    logic [WIDTH-1:0] r_guess;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic [1:0]       w_state_nxt;
    logic [c_IW-1:0]  w_idx_nxt;
    logic [WIDTH-1:0] w_guess_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_err_nxt;

    logic             w_legal;
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_kept;

    // Exactly one comparator flag must be set; anything else aborts.
    assign w_legal = (cmp_in == 3'b100) || (cmp_in == 3'b010) || (cmp_in == 3'b001);
    assign w_bit   = c_ONE << r_idx;
    // Trial bit survives unless the target lies below the guess.
    assign w_kept  = cmp_in[0] ? (r_guess & ~w_bit) : r_guess;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= c_IDX_TOP;
            r_guess  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_TRIAL;
                    w_idx_nxt   = c_IDX_TOP;
                    w_guess_nxt = c_MSB;
                    w_err_nxt   = 1'b0;
                end
            end
            c_ST_TRIAL: begin
                if (!w_legal) begin
                    w_result_nxt = r_guess;
                    w_guess_nxt  = r_guess;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = c_ST_DONE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (cmp_in[1]) begin
                    w_result_nxt = r_guess;
                    w_guess_nxt  = r_guess;
                    w_state_nxt  = c_ST_DONE;
                end
`endif
                else if (r_idx == '0) begin
                    w_result_nxt = w_kept;
                    w_guess_nxt  = w_kept;
                    w_state_nxt  = c_ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx - c_IDX_ONE;
                    w_guess_nxt = w_kept | (w_bit >> 1);
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (r_state == c_ST_TRIAL);
        done   = (r_state == c_ST_DONE);
        guess  = r_guess;
        result = r_result;
        err    = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_search_ctrl
// Purpose  : Scoreboard bench for sar_search_ctrl. A comparator model closes
//            the loop around the DUT; expected trial guesses and completions
//            are queued when a start is accepted and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

    localparam int W = 4;
    localparam logic [2:0] c_ILLEGAL [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic [2:0]   cmp_in;
    logic [W-1:0] guess;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_in (cmp_in),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] gq[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    bit           rst_prev = 1'b0;
    logic [W-1:0] last_res = '0;
    logic         last_err = 1'b0;

    logic [W-1:0] target    = '0;
    logic         bad_en    = 1'b0;
    logic [W-1:0] bad_guess = '0;
    logic [2:0]   bad_code  = 3'b000;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst_n;
    end

    // External comparator, optionally corrupted on one chosen trial value.
    always_comb begin
        if (bad_en && (guess == bad_guess))
            cmp_in = bad_code;
        else
            cmp_in = {target > guess, target == guess, target < guess};
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: trial i presents the target's top i bits followed by a
    // single 1 at bit W-1-i. Successful convergence always yields the target.
    task automatic push_expect(input logic [W-1:0] t, input bit bad, input int j);
        exp_t e;
        int   g;
        int   tt;
        tt     = int'(t);
        e.res  = t;
        e.err  = 1'b0;
        e.lat  = W;
        e.acc  = cyc;
        bad_en = 1'b0;
        for (int i = 0; i < W; i++) begin
            g = (tt & ~((1 << (W - i)) - 1)) | (1 << (W - 1 - i));
            gq.push_back(W'(g));
            if (bad && i == j) begin
                bad_en    = 1'b1;
                bad_guess = W'(g);
                e.res     = W'(g);
                e.err     = 1'b1;
                e.lat     = i + 1;
                break;
            end
`ifdef SAR_EARLY_EXIT_EN
            if (g == tt) begin
                e.lat = i + 1;
                break;
            end
`endif
        end
        sb.push_back(e);
    endtask

    // Called just after a rising edge; drives one cycle of stimulus.
    task automatic step(input bit st, input logic [W-1:0] t, input bit bad,
                        input int j, input logic [2:0] code);
        start = st;
        if (st && rst_n && !busy && !done) begin
            target   = t;
            bad_code = code;
            push_expect(t, bad, j);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 0, 3'b000);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] g;
        if (!rst_prev) begin
            check("rst_guess",  int'(guess),  0);
            check("rst_result", int'(result), 0);
            check("rst_busy",   int'(busy),   0);
            check("rst_done",   int'(done),   0);
            check("rst_err",    int'(err),    0);
            last_res = '0;
            last_err = 1'b0;
        end else if (busy) begin
            check("busy_without_done", int'(done), 0);
            if (gq.size() == 0) begin
                check("unexpected_trial", 1, 0);
            end else begin
                g = gq.pop_front();
                check("trial_guess", int'(guess), int'(g));
            end
        end else if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_result",      int'(result), int'(e.res));
                check("done_err",         int'(err),    int'(e.err));
                check("done_guess",       int'(guess),  int'(e.res));
                check("done_latency",     cyc - e.acc - 1, e.lat);
                check("missing_trials",   gq.size(), 0);
                last_res = e.res;
                last_err = e.err;
            end
        end else begin
            check("idle_result", int'(result), int'(last_res));
            check("idle_guess",  int'(guess),  int'(last_res));
            check("idle_err",    int'(err),    int'(last_err));
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // start held through reset must be ignored
        repeat (2) step(1'b1, '0, 1'b0, 0, 3'b000);
        // first edge with rst_n=1 accepts the start
        rst_n = 1'b1;
        step(1'b1, W'(4'b1011), 1'b0, 0, 3'b000);
        idle_cycles(W + 3);

        // illegal comparator code on the first trial, then a clean search
        step(1'b1, W'($urandom), 1'b1, 0, 3'b000);
        idle_cycles(W + 3);
        step(1'b1, W'($urandom), 1'b0, 0, 3'b000);
        idle_cycles(W + 3);

        // reset during the second trial, then a full restart
        step(1'b1, W'($urandom), 1'b0, 0, 3'b000);
        step(1'b0, '0, 1'b0, 0, 3'b000);
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0, 0, 3'b000);
        gq.delete();
        sb.delete();
        bad_en = 1'b0;
        rst_n  = 1'b1;
        step(1'b1, W'($urandom), 1'b0, 0, 3'b000);
        idle_cycles(W + 3);

        // start held continuously: back-to-back searches
        repeat (6 * (W + 2)) step(1'b1, W'($urandom), 1'b0, 0, 3'b000);
        idle_cycles(W + 3);

        // random starts, targets and occasional illegal codes
        repeat (400) begin
            step(1'b1 & ($urandom % 2 == 0), W'($urandom), ($urandom % 6) == 0,
                 int'($urandom % W), c_ILLEGAL[$urandom % 5]);
        end
        idle_cycles(W + 3);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
